aoc_tt_io_bridge: RTL

Parametrised pin-side bridge between the TinyTapeout host interface and any Advent-of-HardCaml solver core. It turns slow, bit-banged host control lines into single-cycle strobes and buffers ASCII input bytes in a small FIFO with a valid/ready handshake toward the core. It captures NUM_RESULTS result words on core completion and serves them byte-by-byte, with a host-selectable result channel and wrap-around readout. It generalises the fixed 32-bit, single-result, shift-out readout of the day-4 top level.

---
 rtl/aoc_io_pkg.sv | 18 +
 rtl/aoc_byte_fifo.sv | 75 +++++++
 rtl/aoc_tt_io_bridge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/aoc_io_pkg.sv
// Shared types and sizing helpers for the AoC TinyTapeout pin bridge and its FIFO.
package aoc_io_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned SYNC_DEPTH = 2;

  // Bytes needed to carry a w-bit word.
  function automatic int unsigned nbytes(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

  // Select width for n choices, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/aoc_byte_fifo.sv
// Small byte FIFO with registered head/full/empty; push while full is accepted
// only when a pop happens in the same cycle.
module aoc_byte_fifo
  import aoc_io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  byte_t            mem_q [DEPTH];
  byte_t            mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  byte_t            head_q, head_d;
  logic             do_push, do_pop;

  // Next head is read from the post-update storage so a fresh push shows up one cycle later.
  always_comb begin
    do_pop   = pop & ~empty_q;
    do_push  = push & (~full_q | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    head_d  = empty_d ? 8'h00 : mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = head_q;

endmodule

// File: rtl/aoc_tt_io_bridge.sv
// Pin-side bridge between TinyTapeout host lines and an AoC solver core.
// Define AOC_IO_SYNC_EN to pass host control pins through 2-flop synchronisers.
module aoc_tt_io_bridge
  import aoc_io_pkg::*;
#(
  parameter int unsigned  RESULT_W    = 32,
  parameter int unsigned  NUM_RESULTS = 2,
  parameter int unsigned  FIFO_DEPTH  = 4,
  localparam int unsigned SEL_W       = sel_w(NUM_RESULTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      host_data,
  input  logic                            host_valid,
  input  logic                            host_start,
  input  logic                            host_read,
  input  logic [SEL_W-1:0]                host_sel,
  output logic                            host_ready,
  output logic                            err_overflow,
  output logic [7:0]                      core_data,
  output logic                            core_valid,
  input  logic                            core_ready,
  output logic                            core_start,
  input  logic                            core_done,
  input  logic [NUM_RESULTS*RESULT_W-1:0] core_result,
  output logic [7:0]                      out_byte,
  output logic                            out_valid,
  output logic                            out_last
);

  localparam int unsigned NBYTES = nbytes(RESULT_W);
  localparam int unsigned IDX_W  = sel_w(NBYTES);
  localparam int unsigned PAD_W  = NBYTES * 8;

  byte_t            line_data;
  logic             line_valid, line_start, line_read;
  logic [SEL_W-1:0] line_sel;

`ifdef AOC_IO_SYNC_EN
  localparam int unsigned SYNC_W = 8 + 3 + SEL_W;
  localparam logic [SYNC_W-1:0] SYNC_RST = {8'h00, 3'b111, {SEL_W{1'b0}}};

  logic [SYNC_W-1:0] sync_q [SYNC_DEPTH];
  logic [SYNC_W-1:0] sync_d [SYNC_DEPTH];

  // Data rides the same pipe as the strobes so a byte stays paired with its valid edge.
  always_comb begin
    sync_d[0] = {host_data, host_valid, host_start, host_read, host_sel};
    for (int unsigned i = 1; i < SYNC_DEPTH; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '{default: SYNC_RST};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign {line_data, line_valid, line_start, line_read, line_sel} = sync_q[SYNC_DEPTH-1];
`else
  assign {line_data, line_valid, line_start, line_read, line_sel} =
    {host_data, host_valid, host_start, host_read, host_sel};
`endif

  logic                valid_prev_q, valid_prev_d;
  logic                start_prev_q, start_prev_d;
  logic                read_prev_q, read_prev_d;
  logic [SEL_W-1:0]    sel_prev_q, sel_prev_d;
  logic [RESULT_W-1:0] res_q [NUM_RESULTS];
  logic [RESULT_W-1:0] res_d [NUM_RESULTS];
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                err_q, err_d;
  logic                core_start_q, core_start_d;

  logic push_stb, start_stb, read_stb, sel_chg, pop;
  logic fifo_full, fifo_empty;
  byte_t fifo_head;

  aoc_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_stb),
    .push_data (line_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Strobes, overflow flag, capture and readout index; start beats done beats sel beats read.
  always_comb begin
    push_stb  = line_valid & ~valid_prev_q;
    start_stb = line_start & ~start_prev_q;
    read_stb  = line_read & ~read_prev_q;
    sel_chg   = (line_sel != sel_prev_q);
    pop       = core_ready & ~fifo_empty;

    valid_prev_d = line_valid;
    start_prev_d = line_start;
    read_prev_d  = line_read;
    sel_prev_d   = line_sel;
    core_start_d = start_stb;

    err_d       = err_q;
    res_d       = res_q;
    byte_idx_d  = byte_idx_q;
    out_valid_d = out_valid_q;

    if (start_stb) begin
      err_d = 1'b0;
    end else if (push_stb & fifo_full & ~pop) begin
      err_d = 1'b1;
    end

    if (start_stb) begin
      out_valid_d = 1'b0;
      byte_idx_d  = '0;
    end else if (core_done) begin
      for (int unsigned k = 0; k < NUM_RESULTS; k++) begin
        res_d[k] = core_result[k*RESULT_W +: RESULT_W];
      end
      out_valid_d = 1'b1;
      byte_idx_d  = '0;
    end else if (sel_chg) begin
      byte_idx_d = '0;
    end else if (read_stb & out_valid_q) begin
      byte_idx_d = (byte_idx_q == IDX_W'(NBYTES - 1)) ? '0 : byte_idx_q + IDX_W'(1);
    end

    out_last_d = out_valid_d & (byte_idx_d == IDX_W'(NBYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_prev_q <= 1'b1;
      start_prev_q <= 1'b1;
      read_prev_q  <= 1'b1;
      sel_prev_q   <= '0;
      res_q        <= '{default: '0};
      byte_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      valid_prev_q <= valid_prev_d;
      start_prev_q <= start_prev_d;
      read_prev_q  <= read_prev_d;
      sel_prev_q   <= sel_prev_d;
      res_q        <= res_d;
      byte_idx_q   <= byte_idx_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
    end
  end

  logic [RESULT_W-1:0] sel_word;
  logic [PAD_W-1:0]    sel_padded;

  // Readout byte: out-of-range channels read zero, top byte zero-padded.
  always_comb begin
    sel_word   = '0;
    sel_padded = '0;
    out_byte   = 8'h00;
    for (int unsigned k = 0; k < NUM_RESULTS; k++) begin
      if (line_sel == SEL_W'(k)) begin
        sel_word = res_q[k];
      end
    end
    sel_padded[RESULT_W-1:0] = sel_word;
    if (out_valid_q) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (byte_idx_q == IDX_W'(b)) begin
          out_byte = sel_padded[b*8 +: 8];
        end
      end
    end
  end

  assign host_ready   = ~fifo_full;
  assign core_valid   = ~fifo_empty;
  assign core_data    = fifo_head;
  assign err_overflow = err_q;
  assign core_start   = core_start_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;

endmodule
